// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-requester memory arbiter.
//   state_e  - arbiter sequencer states
//   NUM_REQ  - number of requesters
//   owner_t  - requester index type
package mem_arb_pkg;

   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned OWNER_W = $clog2(NUM_REQ);

   typedef logic [OWNER_W-1:0] owner_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick.
//   req         in  - request vector, bit n = requester n
//   last_served in  - requester served most recently
//   valid       out - some requester is eligible
//   winner      out - chosen requester; on a tie the one not served last
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  owner_t             last_served,
   output logic               valid,
   output owner_t             winner
);

   always_comb begin
      valid  = |req;
      winner = owner_t'(1'b0);
      case (req)
         2'b01:   winner = owner_t'(1'b0);
         2'b10:   winner = owner_t'(1'b1);
         2'b11:   winner = ~last_served;
         default: winner = owner_t'(1'b0);
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two requesters onto one data memory (round-robin),
// drives the memory write/read ports and returns registered read data.
//   clk_i, rst_i            - clock, synchronous active-high reset
//   req_i/we_i/lock_i       - per-requester request, write select, lock hint
//   addr0_i/addr1_i         - requester addresses
//   wdata0_i/wdata1_i       - requester write data
//   ack_o                   - access performed this cycle (per requester)
//   rvalid_o/rdata_o        - read data return, cycle after a read ack
//   mem_*                   - memory write/read port (combinational read data in)
// Optional build macro MEM_ARB_LOCK_EN: honours lock_i so an owner can keep
// ownership across consecutive accesses (read-modify-write).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned width = 64,
   parameter int unsigned depth = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [NUM_REQ-1:0] we_i,
   input  logic [NUM_REQ-1:0] lock_i,
   input  logic [depth-1:0]   addr0_i,
   input  logic [depth-1:0]   addr1_i,
   input  logic [width-1:0]   wdata0_i,
   input  logic [width-1:0]   wdata1_i,
   output logic [NUM_REQ-1:0] ack_o,
   output logic [NUM_REQ-1:0] rvalid_o,
   output logic [width-1:0]   rdata_o,
   output logic               mem_wr_en_o,
   output logic [depth-1:0]   mem_addr_wr_o,
   output logic [width-1:0]   mem_data_wr_o,
   output logic               mem_rd_en_o,
   output logic [depth-1:0]   mem_addr_rd_o,
   input  logic [width-1:0]   mem_data_rd_i
);

   state_e             state_q, state_d;
   owner_t             owner_q, owner_d;
   owner_t             last_q, last_d;
   logic               locked_q, locked_d;
   logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
   logic [width-1:0]   rdata_q, rdata_d;

   logic [NUM_REQ-1:0] owner_mask;
   logic [NUM_REQ-1:0] elig;
   logic               own_req;
   logic               own_we;
   logic               own_lock;
   logic [depth-1:0]   own_addr;
   logic [width-1:0]   own_wdata;
   logic               pick_valid;
   owner_t             pick_winner;

   // Current owner's request fields
   assign owner_mask = NUM_REQ'(1) << owner_q;
   assign own_req    = req_i[owner_q];
   assign own_we     = we_i[owner_q];
   assign own_addr   = (owner_q == owner_t'(1'b1)) ? addr1_i  : addr0_i;
   assign own_wdata  = (owner_q == owner_t'(1'b1)) ? wdata1_i : wdata0_i;

`ifdef MEM_ARB_LOCK_EN
   assign own_lock = lock_i[owner_q];
`else
   logic lock_unused;
   assign own_lock    = 1'b0;
   assign lock_unused = ^lock_i;
`endif

   // While locked only the owner may be granted
   assign elig = locked_q ? (req_i & owner_mask) : req_i;

   rr_pick2 u_pick (
      .req         (elig),
      .last_served (last_q),
      .valid       (pick_valid),
      .winner      (pick_winner)
   );

   // Next-state, memory port drive and read-return staging
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_d        = last_q;
      locked_d      = locked_q;
      rvalid_d      = '0;
      rdata_d       = rdata_q;
      ack_o         = '0;
      mem_wr_en_o   = 1'b0;
      mem_addr_wr_o = '0;
      mem_data_wr_o = '0;
      mem_rd_en_o   = 1'b0;
      mem_addr_rd_o = '0;

      case (state_q)
         IDLE: begin
            if (locked_q && !own_req && !own_lock) begin
               locked_d = 1'b0;
            end
            if (pick_valid) begin
               owner_d = pick_winner;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            state_d = IDLE;
            // A dropped request aborts silently and leaves the pointer alone
            if (own_req) begin
               ack_o    = owner_mask;
               last_d   = owner_q;
               locked_d = own_lock;
               if (own_we) begin
                  mem_wr_en_o   = 1'b1;
                  mem_addr_wr_o = own_addr;
                  mem_data_wr_o = own_wdata;
               end else begin
                  mem_rd_en_o   = 1'b1;
                  mem_addr_rd_o = own_addr;
                  rvalid_d      = owner_mask;
                  rdata_d       = mem_data_rd_i;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; last_q resets to 1 so requester 0 wins the first tie
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         owner_q  <= owner_t'(1'b0);
         last_q   <= owner_t'(1'b1);
         locked_q <= 1'b0;
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         locked_q <= locked_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer for the single data memory (depth-addressed, combinational read, posedge write). Requester 0 is the core load/store path; requester 1 is a debug/DMA port. The arbiter serialises accesses round-robin, drives the memory's write/read ports, and returns registered read data. It sits between both requesters and the memory instance.

Parameters:
width, 64, data word width; must match the memory
depth, 5, address width; memory holds 2**depth words

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous, active-high reset
req_i  input  2  access request, bit n = requester n; held until ack
we_i  input  2  1 = write, 0 = read, per requester
lock_i  input  2  keep ownership after this access (used only with MEM_ARB_LOCK_EN)
addr0_i  input  depth  requester 0 address
addr1_i  input  depth  requester 1 address
wdata0_i  input  width  requester 0 write data
wdata1_i  input  width  requester 1 write data
ack_o  output  2  one-cycle pulse; the access is performed in this cycle
rvalid_o  output  2  one-cycle pulse, cycle after a read ack
rdata_o  output  width  registered read data, shared; valid when any rvalid_o is high
mem_wr_en_o  output  1  to memory write enable
mem_addr_wr_o  output  depth  to memory write address
mem_data_wr_o  output  width  to memory write data
mem_rd_en_o  output  1  to memory read enable
mem_addr_rd_o  output  depth  to memory read address
mem_data_rd_i  input  width  from memory read data (combinational)

Behaviour:
- Reset (rst_i high at posedge): state IDLE, owner 0, rr pointer favours requester 0, locked cleared, ack_o/rvalid_o 0, rdata_o 0. All mem_* outputs are 0 whenever state is not ACCESS.
- FSM: IDLE, ACCESS.
- IDLE: if req_i nonzero, pick a winner, register owner, go to ACCESS. If only one requester asserts req, it wins. If both assert, the requester not served last wins. After reset, requester 0 wins a tie.
- ACCESS: memory ports are driven from the owner's inputs. Write: mem_wr_en_o=1, mem_addr_wr_o/mem_data_wr_o = owner addr/wdata. Read: mem_rd_en_o=1, mem_addr_rd_o = owner addr, and rdata_o <= mem_data_rd_i at the closing edge.
  - ack_o[owner]=1 in this cycle. rr pointer is updated so the other requester has priority. Next state is always IDLE.
- Latency: req seen in cycle 0, ack in cycle 1, rvalid (reads) in cycle 2. Peak throughput is one access per 2 cycles.
- Requester rules: hold req/we/addr/wdata stable up to and including the ack cycle. Keeping req high after ack requests a new access.
- Dropping req while in ACCESS: no memory enable, no ack, return to IDLE, pointer unchanged.
- rdata_o holds its last value until the next read completes. It is never cleared except by reset.
- Reset mid-ACCESS: the access is suppressed at that edge (no rdata update, no rvalid). A write already enabled in that cycle may still commit in memory.

Optional Feature:
MEM_ARB_LOCK_EN
- Defined: if lock_i[owner]=1 in the ack cycle, locked is set. While locked, IDLE grants only the owner and the other request waits.
- locked clears when the owner is acked with lock_i[owner]=0, or when in IDLE with req_i[owner]=0 and lock_i[owner]=0.
- Use case: read-modify-write.
- Not defined: lock_i is ignored and locked stays 0. The port remains present.

Decomposition:
- Package mem_arb_pkg: state enum {IDLE, ACCESS}, constant NUM_REQ=2, owner index type.
- Sub-module rr_pick2: inputs req[1:0] and last_served; outputs valid and winner; purely combinational. The FSM, data muxing and rdata register live in mem_arbiter.

Test Plan:
- Req0 write addr 3, data 0xDEAD_BEEF_0000_0001 -> ack_o=01 in cycle 1 with mem_wr_en_o=1 and mem_addr_wr_o=3. Then req0 read addr 3 -> rvalid_o=01 two cycles after req, rdata_o=0xDEAD_BEEF_0000_0001.
- Both req held continuously (reads addr 1 / addr 2) -> ack order 01,10,01,10 every other cycle. rdata alternates mem[1], mem[2].
- Req1 alone, then both at once -> requester 0 wins the tie after req1 was served.
- Assert rst_i during ACCESS of a read -> next cycle ack_o=0, rvalid_o=0, rdata_o=0, state IDLE.
- Req0 drops in ACCESS cycle -> no ack, mem_rd_en_o=0 and mem_wr_en_o=0. Next grant still honours the unchanged pointer.
- With MEM_ARB_LOCK_EN, req0 read with lock=1, req1 pending -> req0 gets the next write before req1. Lock=0 on that ack -> req1 granted next.
